// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the SimuladorAC control unit.
// Opcodes, FSM states, ALU op codes and instruction field positions.
package ctrl_pkg;

   localparam int CTRL_DATA_W = 8;
   localparam int CTRL_ADDR_W = 8;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_LD  = 4'h2;
   localparam logic [3:0] OP_ST  = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_JC  = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] S_FETCH0 = 3'd0;
   localparam logic [2:0] S_FETCH1 = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   localparam int OP_HI = 7;
   localparam int OP_LO = 4;
   localparam int RD_HI = 3;
   localparam int RD_LO = 2;
   localparam int RS_HI = 1;
   localparam int RS_LO = 0;

endpackage

// File: rtl/reg_bank.sv
// reg_bank: 4-entry register file with one synchronous write port
// and two asynchronous read ports.
module reg_bank
   import ctrl_pkg::*;
#(
   parameter int DATA_W = CTRL_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [1:0]        waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [1:0]        raddr_a_i,
   output logic [DATA_W-1:0] rdata_a_o,
   input  logic [1:0]        raddr_b_i,
   output logic [DATA_W-1:0] rdata_b_o
);

   logic [DATA_W-1:0] r_regs [4];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      end else if (we_i) begin
         r_regs[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = r_regs[raddr_a_i];
   assign rdata_b_o = r_regs[raddr_b_i];

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for SimuladorAC.
// Owns PC, flags and register bank; drives the ALU and a req/ack memory port.
module control_unit
   import ctrl_pkg::*;
#(
   parameter int DATA_W = CTRL_DATA_W,
   parameter int ADDR_W = CTRL_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic [DATA_W-1:0] alu_y_o,
   output logic [DATA_W-1:0] alu_x_o,
   output logic [2:0]        alu_op_o,
   input  logic [DATA_W-1:0] alu_r_i,
   input  logic              alu_fz_i,
   input  logic              alu_fc_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              fz_o,
   output logic              fc_o,
   output logic              halted_o
);

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_ir0;
   logic [DATA_W-1:0] r_ir1;
   logic              r_fz;
   logic              r_fc;

   logic [3:0]        w_op;
   logic [1:0]        w_rd;
   logic [1:0]        w_rs;
   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0] w_rs_data;
   logic [DATA_W-1:0] w_wdata;
   logic              w_we;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_target;

   assign w_op     = r_ir0[OP_HI:OP_LO];
   assign w_rd     = r_ir0[RD_HI:RD_LO];
   assign w_rs     = r_ir0[RS_HI:RS_LO];
   assign w_pc_inc = r_pc + ADDR_W'(1);
   assign w_target = ADDR_W'(r_ir1);

   reg_bank #(.DATA_W(DATA_W)) u_regs (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .we_i      (w_we),
      .waddr_i   (w_rd),
      .wdata_i   (w_wdata),
      .raddr_a_i (w_rd),
      .rdata_a_o (w_rd_data),
      .raddr_b_i (w_rs),
      .rdata_b_o (w_rs_data)
   );

   always_comb begin
      mem_addr_o  = '0;
      mem_rd_o    = 1'b0;
      mem_wr_o    = 1'b0;
      mem_wdata_o = '0;
      alu_op_o    = ALU_ADD;
      w_we        = 1'b0;
      w_wdata     = r_ir1;
      case (r_state)
         S_FETCH0, S_FETCH1: begin
            mem_rd_o   = 1'b1;
            mem_addr_o = r_pc;
         end
         S_EXEC: begin
            case (w_op)
               OP_LDI: w_we = 1'b1;
               OP_ADD: begin
                  w_we    = 1'b1;
                  w_wdata = alu_r_i;
               end
               OP_SUB: begin
                  alu_op_o = ALU_SUB;
                  w_we     = 1'b1;
                  w_wdata  = alu_r_i;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            mem_addr_o = w_target;
            if (w_op == OP_LD) begin
               mem_rd_o = 1'b1;
               w_we     = mem_ack_i;
               w_wdata  = mem_rdata_i;
            end else begin
               mem_wr_o    = 1'b1;
               mem_wdata_o = w_rs_data;
            end
         end
         default: ;
      endcase
      // Requests must drop the instant reset asserts, before any edge.
      if (!rst_ni) begin
         mem_rd_o    = 1'b0;
         mem_wr_o    = 1'b0;
         mem_addr_o  = '0;
         mem_wdata_o = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_FETCH0;
         r_pc    <= '0;
         r_ir0   <= '0;
         r_ir1   <= '0;
         r_fz    <= 1'b0;
         r_fc    <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH0: if (mem_ack_i) begin
               r_ir0   <= mem_rdata_i;
               r_pc    <= w_pc_inc;
               r_state <= S_FETCH1;
            end
            S_FETCH1: if (mem_ack_i) begin
               r_ir1   <= mem_rdata_i;
               r_pc    <= w_pc_inc;
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_state <= S_FETCH0;
               case (w_op)
                  OP_LD, OP_ST: r_state <= S_MEM;
                  OP_ADD, OP_SUB: begin
                     r_fz <= alu_fz_i;
                     r_fc <= alu_fc_i;
                  end
                  OP_JMP: r_pc <= w_target;
                  OP_JZ: if (r_fz) r_pc <= w_target;
                  OP_JC: if (r_fc) r_pc <= w_target;
                  OP_HLT: r_state <= S_HALT;
                  OP_NOP: ;
                  default: ;
               endcase
            end
            S_MEM: if (mem_ack_i) r_state <= S_FETCH0;
            default: ;
         endcase
      end
   end

   assign alu_y_o  = w_rd_data;
   assign alu_x_o  = w_rs_data;
   assign pc_o     = r_pc;
   assign fz_o     = r_fz;
   assign fc_o     = r_fc;
   assign halted_o = (r_state == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed programs against an instruction-level model
// that predicts the per-cycle bus/flag timeline, plus literal pins.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] mem_addr_o;
   logic       mem_rd_o;
   logic       mem_wr_o;
   logic [7:0] mem_wdata_o;
   logic [7:0] mem_rdata;
   logic       ack;
   logic [7:0] alu_y_o;
   logic [7:0] alu_x_o;
   logic [2:0] alu_op_o;
   logic [7:0] alu_r;
   logic       alu_fz;
   logic       alu_fc;
   logic [7:0] pc_o;
   logic       fz_o;
   logic       fc_o;
   logic       halted_o;

   always #5 clk = ~clk;

   control_unit dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .mem_addr_o  (mem_addr_o),
      .mem_rd_o    (mem_rd_o),
      .mem_wr_o    (mem_wr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata),
      .mem_ack_i   (ack),
      .alu_y_o     (alu_y_o),
      .alu_x_o     (alu_x_o),
      .alu_op_o    (alu_op_o),
      .alu_r_i     (alu_r),
      .alu_fz_i    (alu_fz),
      .alu_fc_i    (alu_fc),
      .pc_o        (pc_o),
      .fz_o        (fz_o),
      .fc_o        (fc_o),
      .halted_o    (halted_o)
   );

   // Combinational ALU: add, or subtract with borrow in the carry flag.
   logic [8:0] alu_t;
   always_comb begin
      if (alu_op_o == 3'b001) alu_t = {1'b0, alu_y_o} - {1'b0, alu_x_o};
      else alu_t = {1'b0, alu_y_o} + {1'b0, alu_x_o};
      alu_r  = alu_t[7:0];
      alu_fc = alu_t[8];
      alu_fz = (alu_t[7:0] == 8'h00);
   end

   // Memory responder with a programmable number of wait cycles.
   logic [7:0] mem [256];
   int         ack_dly = 0;
   int         wcnt = 0;
   logic       spur = 1'b0;
   int         wr_cnt = 0;
   logic [7:0] wr_addr = 8'h00;
   logic [7:0] wr_data = 8'h00;

   initial begin
      ack = 1'b0;
      mem_rdata = 8'h00;
   end

   always @(negedge clk) begin
      if (rst_n && (mem_rd_o || mem_wr_o)) begin
         if (wcnt == ack_dly) begin
            ack = 1'b1;
            mem_rdata = mem[mem_addr_o];
         end else begin
            ack = 1'b0;
            wcnt++;
         end
      end else begin
         ack = spur && rst_n;
         wcnt = 0;
      end
   end

   always @(posedge clk) begin
      if (ack && mem_wr_o) begin
         mem[mem_addr_o] = mem_wdata_o;
         wr_addr = mem_addr_o;
         wr_data = mem_wdata_o;
         wr_cnt++;
      end
      if (ack) wcnt = 0;
   end

   // Instruction-level model producing the expected per-cycle timeline.
   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [2:0] op;
      logic [7:0] pc;
      logic       fz;
      logic       fc;
      logic       hlt;
      logic       xv;
      logic [7:0] y;
      logic [7:0] x;
   } exp_t;

   exp_t       q[$];
   logic [7:0] mm [256];
   logic [7:0] rr [4];
   logic [7:0] m_pc;
   logic       m_fz;
   logic       m_fc;
   logic       m_hlt;

   task automatic push(input logic rd, input logic wr, input logic [7:0] a,
                       input logic [7:0] wd, input logic [2:0] op,
                       input logic xv, input logic [7:0] y, input logic [7:0] x);
      exp_t e;
      e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd; e.op = op;
      e.pc = m_pc; e.fz = m_fz; e.fc = m_fc; e.hlt = m_hlt;
      e.xv = xv; e.y = y; e.x = x;
      q.push_back(e);
   endtask

   task automatic build(input int d);
      logic [7:0] a0, b0, b1;
      logic [3:0] op;
      logic [1:0] fd, fs;
      logic [8:0] t;
      q.delete();
      m_pc = 8'h00; m_fz = 1'b0; m_fc = 1'b0; m_hlt = 1'b0;
      for (int i = 0; i < 4; i++) rr[i] = 8'h00;
      for (int k = 0; k < 40 && !m_hlt; k++) begin
         a0 = m_pc;
         b0 = mm[a0];
         repeat (d + 1) push(1'b1, 1'b0, a0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00);
         m_pc = a0 + 8'd1;
         b1 = mm[m_pc];
         repeat (d + 1) push(1'b1, 1'b0, m_pc, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00);
         m_pc = m_pc + 8'd1;
         op = b0[7:4]; fd = b0[3:2]; fs = b0[1:0];
         push(1'b0, 1'b0, 8'h00, 8'h00, (op == 4'd5) ? 3'b001 : 3'b000,
              (op == 4'd4) || (op == 4'd5), rr[fd], rr[fs]);
         case (op)
            4'd1: rr[fd] = b1;
            4'd2: begin
               repeat (d + 1) push(1'b1, 1'b0, b1, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00);
               rr[fd] = mm[b1];
            end
            4'd3: begin
               repeat (d + 1) push(1'b0, 1'b1, b1, rr[fs], 3'd0, 1'b0, 8'h00, 8'h00);
               mm[b1] = rr[fs];
            end
            4'd4, 4'd5: begin
               if (op == 4'd4) t = {1'b0, rr[fd]} + {1'b0, rr[fs]};
               else t = {1'b0, rr[fd]} - {1'b0, rr[fs]};
               rr[fd] = t[7:0];
               m_fc = t[8];
               m_fz = (t[7:0] == 8'h00);
            end
            4'd6: m_pc = b1;
            4'd7: if (m_fz) m_pc = b1;
            4'd8: if (m_fc) m_pc = b1;
            4'd15: begin
               m_hlt = 1'b1;
               repeat (4) push(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00);
            end
            default: ;
         endcase
      end
   endtask

   int   checks = 0;
   int   errors = 0;
   logic chk_en = 1'b0;
   int   cyc = 0;
   int   first_halt = -1;
   int   aop_cnt = 0;
   int   rd_cnt = 0;
   exp_t e;

   always @(negedge clk) begin
      if (chk_en) begin
         if (halted_o && first_halt < 0) first_halt = cyc;
         if (alu_op_o == 3'b001) aop_cnt++;
         if (mem_rd_o) rd_cnt++;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ((mem_rd_o !== e.rd) || (mem_wr_o !== e.wr) ||
                ((e.rd || e.wr) && (mem_addr_o !== e.addr)) ||
                (e.wr && (mem_wdata_o !== e.wdata)) ||
                (alu_op_o !== e.op) || (pc_o !== e.pc) ||
                (fz_o !== e.fz) || (fc_o !== e.fc) || (halted_o !== e.hlt) ||
                (e.xv && ((alu_y_o !== e.y) || (alu_x_o !== e.x)))) begin
               errors++;
               $display("FAIL cycle %0d: got rd=%b wr=%b a=%h wd=%h op=%h pc=%h z=%b c=%b h=%b y=%h x=%h, expected rd=%b wr=%b a=%h wd=%h op=%h pc=%h z=%b c=%b h=%b y=%h x=%h",
                        cyc, mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o, alu_op_o,
                        pc_o, fz_o, fc_o, halted_o, alu_y_o, alu_x_o,
                        e.rd, e.wr, e.addr, e.wdata, e.op, e.pc, e.fz, e.fc,
                        e.hlt, e.y, e.x);
            end
         end
         cyc++;
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic clear();
      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'h00;
         mm[i] = 8'h00;
      end
   endtask

   task automatic ld(input logic [7:0] a, input logic [7:0] v);
      mem[a] = v;
      mm[a] = v;
   endtask

   task automatic run(input int d, input logic sp);
      int n;
      rst_n = 1'b0;
      ack_dly = d;
      spur = sp;
      build(d);
      wr_cnt = 0; aop_cnt = 0; rd_cnt = 0; first_halt = -1; cyc = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      n = 0;
      while (q.size() > 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      #1 chk_en = 1'b0;
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d entries left, expected 0", q.size());
      end
   endtask

   task automatic load_t1();
      clear();
      ld(8'h00, 8'h10); ld(8'h01, 8'h05);
      ld(8'h02, 8'h14); ld(8'h03, 8'h03);
      ld(8'h04, 8'h41); ld(8'h05, 8'h00);
      ld(8'h06, 8'h30); ld(8'h07, 8'h80);
      ld(8'h08, 8'hF0); ld(8'h09, 8'h00);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rd", 32'(mem_rd_o), 0);
      chk("rst_wr", 32'(mem_wr_o), 0);
      chk("rst_addr", 32'(mem_addr_o), 0);
      chk("rst_wdata", 32'(mem_wdata_o), 0);
      chk("rst_aluop", 32'(alu_op_o), 0);
      chk("rst_pc", 32'(pc_o), 0);
      chk("rst_flags", 32'({fz_o, fc_o}), 0);
      chk("rst_halted", 32'(halted_o), 0);

      // Add and store.
      load_t1();
      run(0, 1'b0);
      chk("t1_wr_cnt", wr_cnt, 1);
      chk("t1_wr_addr", 32'(wr_addr), 32'h80);
      chk("t1_wr_data", 32'(wr_data), 32'h08);
      chk("t1_flags", 32'({fz_o, fc_o}), 0);
      chk("t1_halted", 32'(halted_o), 1);
      chk("t1_pc", 32'(pc_o), 32'h0A);
      chk("t1_halt_cyc", first_halt, 16);

      // Subtract to zero, then taken JZ; stray acks while idle.
      clear();
      ld(8'h00, 8'h10); ld(8'h01, 8'h03);
      ld(8'h02, 8'h14); ld(8'h03, 8'h03);
      ld(8'h04, 8'h51); ld(8'h05, 8'h00);
      ld(8'h06, 8'h70); ld(8'h07, 8'h20);
      ld(8'h20, 8'hF0);
      run(0, 1'b1);
      chk("t2_sub_cycles", aop_cnt, 1);
      chk("t2_fz", 32'(fz_o), 1);
      chk("t2_fc", 32'(fc_o), 0);
      chk("t2_pc", 32'(pc_o), 32'h22);
      chk("t2_halt_cyc", first_halt, 15);

      // Carry and JC; a later LDI keeps the flags.
      clear();
      ld(8'h00, 8'h10); ld(8'h01, 8'hFF);
      ld(8'h02, 8'h14); ld(8'h03, 8'h01);
      ld(8'h04, 8'h41); ld(8'h05, 8'h00);
      ld(8'h06, 8'h80); ld(8'h07, 8'h40);
      ld(8'h40, 8'h1C); ld(8'h41, 8'h07);
      ld(8'h42, 8'h30); ld(8'h43, 8'h90);
      ld(8'h44, 8'hF0);
      mem[8'h90] = 8'hAA;
      mm[8'h90] = 8'hAA;
      run(0, 1'b1);
      chk("t3_wr_addr", 32'(wr_addr), 32'h90);
      chk("t3_r0", 32'(wr_data), 0);
      chk("t3_flags", 32'({fz_o, fc_o}), 3);
      chk("t3_pc", 32'(pc_o), 32'h46);
      chk("t3_halt_cyc", first_halt, 22);

      // Three wait cycles on every access.
      clear();
      ld(8'h02, 8'hF0);
      run(3, 1'b0);
      chk("t4_halt_cyc", first_halt, 18);
      chk("t4_rd_cycles", rd_cnt, 16);
      chk("t4_pc", 32'(pc_o), 32'h04);

      // PC wrap: LDI at 0xFF takes its immediate from 0x00.
      clear();
      ld(8'h00, 8'h5A); ld(8'h01, 8'h32);
      ld(8'h02, 8'h60); ld(8'h03, 8'hFF);
      ld(8'hFF, 8'h18);
      run(0, 1'b0);
      chk("t6_wr_addr", 32'(wr_addr), 32'h60);
      chk("t6_r2", 32'(wr_data), 32'h5A);
      chk("t6_pc", 32'(pc_o), 32'h05);
      chk("t6_flags", 32'({fz_o, fc_o}), 2);
      chk("t6_halt_cyc", first_halt, 16);

      // Reset mid-FETCH1 and mid-MEM of a store.
      load_t1();
      ack_dly = 0;
      spur = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("f1_rd", 32'(mem_rd_o), 1);
      chk("f1_addr", 32'(mem_addr_o), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("f1_rst_rd", 32'(mem_rd_o), 0);
      chk("f1_rst_addr", 32'(mem_addr_o), 0);
      chk("f1_rst_pc", 32'(pc_o), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("f1_restart_rd", 32'(mem_rd_o), 1);
      chk("f1_restart_addr", 32'(mem_addr_o), 0);
      repeat (12) @(negedge clk);
      chk("mem_wr", 32'(mem_wr_o), 1);
      chk("mem_addr", 32'(mem_addr_o), 32'h80);
      chk("mem_wdata", 32'(mem_wdata_o), 32'h08);
      #2 rst_n = 1'b0;
      #1;
      chk("mem_rst_wr", 32'(mem_wr_o), 0);
      chk("mem_rst_rd", 32'(mem_rd_o), 0);
      chk("mem_rst_addr", 32'(mem_addr_o), 0);
      chk("mem_rst_wdata", 32'(mem_wdata_o), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("mem_no_write", 32'(mem[8'h80]), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mem_restart_rd", 32'(mem_rd_o), 1);
      chk("mem_restart_addr", 32'(mem_addr_o), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
